// File: rtl/led_sequencer.sv
// led_sequencer: button-selected LED pattern controller with step prescaler and debouncer
module led_sequencer #(
  parameter int STEP_DIV     = 1200000,
  parameter int DEBOUNCE_CYC = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4,
  output logic D5
);
  localparam int CW = $clog2(STEP_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  typedef enum logic [2:0] {OFF, CHASE, BOUNCE, BLINK, COUNT} mode_t;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic s1, s2, btn_db, btn_db_q, tick, adv;
  mode_t mode, mode_n;
  logic [3:0] pat, pat_n;
  logic dir, dir_n, d5, d5_n;
  assign tick = cnt == CW'(STEP_DIV - 1);
  assign adv = btn_db & ~btn_db_q;
  assign {D4, D3, D2, D1} = pat;
  assign D5 = d5;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      btn_db <= 1'b0;
      btn_db_q <= 1'b0;
      dcnt <= '0;
      cnt <= '0;
      mode <= OFF;
      pat <= '0;
      dir <= 1'b0;
      d5 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      btn_db_q <= btn_db;
      if (s2 != btn_db) begin
        if (dcnt == DW'(DEBOUNCE_CYC - 1)) begin
          btn_db <= s2;
          dcnt <= '0;
        end else dcnt <= dcnt + 1'b1;
      end else dcnt <= '0;
      cnt <= (adv || tick) ? '0 : cnt + 1'b1;
      mode <= mode_n;
      pat <= pat_n;
      dir <= dir_n;
      d5 <= d5_n;
    end
  end
  always_comb begin
    mode_n = mode;
    pat_n = pat;
    dir_n = dir;
    d5_n = d5;
    if (mode > COUNT) begin
      mode_n = OFF;
      pat_n = '0;
      dir_n = 1'b0;
      d5_n = 1'b0;
    end else if (adv) begin
      mode_n = mode == OFF ? CHASE : mode == CHASE ? BOUNCE : mode == BOUNCE ? BLINK :
               mode == BLINK ? COUNT : OFF;
      pat_n = (mode_n == CHASE || mode_n == BOUNCE) ? 4'b0001 : mode_n == BLINK ? 4'b1111 : 4'b0000;
      d5_n = mode_n == BLINK;
      dir_n = 1'b0;
    end else if (tick) begin
      case (mode)
        CHASE: pat_n = {pat[2:0], pat[3]};
        BOUNCE: begin
          // dir flips on leaving an end, so D5 marks only the downward run
          if (!dir) begin
            pat_n = pat[3] ? 4'b0100 : pat << 1;
            dir_n = pat[3];
          end else begin
            pat_n = pat >> 1;
            dir_n = pat != 4'b0010;
          end
          d5_n = dir_n;
        end
        BLINK: begin
          pat_n = ~pat;
          d5_n = ~d5;
        end
        COUNT: begin
          pat_n = pat + 1'b1;
          d5_n = pat == 4'b1110;
        end
        default: begin
          pat_n = '0;
          d5_n = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: random and directed button/reset stimulus against a step-index reference model
module tb_led_sequencer;
  localparam int SD = 4;
  localparam int DC = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic D1, D2, D3, D4, D5;
  int checks = 0;
  int errors = 0;
  int s1 = 0, s2 = 0, db = 0, dbq = 0, dcnt = 0, cnt = 0, mode = 0, k = 0;
  led_sequencer #(.STEP_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
    .clk(clk), .rst(rst), .btn(btn), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b (mode %0d step %0d)", tag, got, exp, mode, k);
    end
  endtask
  function automatic logic [4:0] leds(input int md, input int kk);
    int bounce_pat[6] = '{1, 2, 4, 8, 4, 2};
    case (md)
      1: return {1'b0, 4'(1 << (kk % 4))};
      2: return {kk % 6 >= 4, 4'(bounce_pat[kk % 6])};
      3: return (kk % 2 == 0) ? 5'h1f : 5'h00;
      4: return {kk % 16 == 15, 4'(kk % 16)};
      default: return 5'h00;
    endcase
  endfunction
  task automatic cyc(input logic r, input logic b, input string tag);
    bit adv, tick;
    rst = r;
    btn = b;
    @(posedge clk);
    if (r) begin
      s1 = 0; s2 = 0; db = 0; dbq = 0; dcnt = 0; cnt = 0; mode = 0; k = 0;
    end else begin
      adv = db == 1 && dbq == 0;
      tick = cnt == SD - 1;
      dbq = db;
      if (s2 != db) begin
        if (dcnt == DC - 1) begin
          db = s2;
          dcnt = 0;
        end else dcnt++;
      end else dcnt = 0;
      s2 = s1;
      s1 = int'(b);
      cnt = (adv || tick) ? 0 : cnt + 1;
      if (adv) begin
        mode = (mode + 1) % 5;
        k = 0;
      end else if (tick && mode != 0) k++;
    end
    #1 check(tag, {D5, D4, D3, D2, D1}, leds(mode, k));
  endtask
  task automatic press(input int n, input int idle, input string tag);
    repeat (n) cyc(1'b0, 1'b1, tag);
    repeat (idle) cyc(1'b0, 1'b0, tag);
  endtask
  initial begin
    repeat (2) cyc(1'b1, 1'b0, "reset");
    repeat (100) cyc(1'b0, 1'b0, "idle");
    check("idle_end", {D5, D4, D3, D2, D1}, 5'h00);
    press(20, 20, "chase_hold");
    press(2, 10, "short_pulse");
    press(5, 40, "bounce");
    press(6, 30, "blink");
    press(6, 80, "count");
    press(6, 20, "off");
    press(6, 0, "chase_again");
    for (int i = 0; i < 40 && !(mode == 1 && k % 4 == 2); i++) cyc(1'b0, 1'b0, "chase_run");
    check("chase_mid", {D5, D4, D3, D2, D1}, 5'b00100);
    cyc(1'b1, 1'b0, "rst_mid");
    check("rst_mid_zero", {D5, D4, D3, D2, D1}, 5'h00);
    repeat (300) begin
      logic r, b;
      int n;
      r = $urandom_range(0, 29) == 0;
      b = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 12);
      repeat (n) cyc(r, b, "random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
